// File: rtl/thermo_acc_8.sv
`default_nettype none
// ============================================================================
// Module      : thermo_acc_8
// Description : Accumulates a unary bitstream over a window of CYCLE accepted
//               bits into an 8-bit thermometer word for the leading-one
//               priority encoder downstream. Each accepted '1' shifts another
//               '1' in from the LSB. The finished word, an unsaturated ones
//               count and a saturation flag are held under a valid/ready
//               handshake.
//
// Ports       : clk        - sole clock, rising edge
//               rst_n      - asynchronous active-low reset
//               start      - begin (or restart) a window, single-cycle pulse
//               in_valid   - in_bit is valid this cycle
//               in_bit     - unary stream bit
//               in_ready   - block accepts stream bits (window in progress)
//               out_ready  - downstream consumes the result
//               out_valid  - therm / ones_cnt / sat hold a finished result
//               therm      - thermometer word (contiguous ones from bit 0)
//               ones_cnt   - accepted ones in the window, never saturates
//               sat        - a '1' arrived while therm was already 8'hFF
//
// Revision    : 1.0 - initial release
// ============================================================================
module thermo_acc_8 #(
  parameter int CYCLE = 16,
  parameter int CW    = $clog2(CYCLE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [7:0]    therm,
  output logic [CW-1:0] ones_cnt,
  output logic          sat
);

  // Window counter only has to reach CYCLE-1.
  localparam int              WW      = $clog2(CYCLE);
  localparam logic [WW-1:0]   c_WLAST = WW'(CYCLE - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ACC  = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  logic [1:0]    state_q,     state_d;
  logic          in_ready_q,  in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [WW-1:0] wcnt_q,      wcnt_d;
  logic [7:0]    therm_q,     therm_d;
  logic [CW-1:0] ones_q,      ones_d;
  logic          sat_q,       sat_d;

  logic w_accept;
  logic w_last;
  logic w_clear;

  // in_ready_q mirrors state==ACC, so it doubles as the accept qualifier.
  assign w_accept = in_valid & in_ready_q;
  assign w_last   = (wcnt_q == c_WLAST);

  // A start clears the result everywhere except in HOLD, where it only
  // counts together with the handshake so a held result is never lost.
  assign w_clear  = start & ((state_q != c_HOLD) | out_ready);

  // --------------------------------------------------------------------------
  // State register (plus registered handshake flags)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= c_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (start) begin
          state_d = c_ACC;
        end
      end
      c_ACC: begin
        // A start in the same cycle discards the bit, so it cannot close
        // the window.
        if (!start && w_accept && w_last) begin
          state_d = c_HOLD;
        end
      end
      c_HOLD: begin
        if (out_ready) begin
          state_d = start ? c_ACC : c_IDLE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: flags are decoded from the next state and registered so
  // they line up with the state they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready_d  = (state_d == c_ACC);
    out_valid_d = (state_d == c_HOLD);
  end

  // --------------------------------------------------------------------------
  // Accumulator datapath
  // --------------------------------------------------------------------------
  always_comb begin
    wcnt_d  = wcnt_q;
    therm_d = therm_q;
    ones_d  = ones_q;
    sat_d   = sat_q;

    if (w_clear) begin
      wcnt_d  = '0;
      therm_d = 8'h00;
      ones_d  = '0;
      sat_d   = 1'b0;
    end else if ((state_q == c_ACC) && w_accept) begin
      // Hold the counter on the final accept; the next start clears it.
      if (!w_last) begin
        wcnt_d = wcnt_q + WW'(1);
      end
      if (in_bit) begin
        ones_d = ones_q + CW'(1);
        if (therm_q != 8'hFF) begin
          therm_d = {therm_q[6:0], 1'b1};
        end else begin
          sat_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      therm_q <= 8'h00;
      ones_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      therm_q <= therm_d;
      ones_q  <= ones_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign therm     = therm_q;
  assign ones_cnt  = ones_q;
  assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_thermo_acc_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_thermo_acc_8
// Description : Self-checking bench for thermo_acc_8: table of full windows,
//               hand-written corner sequences, then random traffic compared
//               against a window-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thermo_acc_8;

  localparam int CYCLE = 16;
  localparam int CW    = $clog2(CYCLE + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_bit;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [7:0]    therm;
  logic [CW-1:0] ones_cnt;
  logic          sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  thermo_acc_8 #(.CYCLE(CYCLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .therm     (therm),
    .ones_cnt  (ones_cnt),
    .sat       (sat)
  );

  typedef struct {
    logic [15:0] bits;      // bit k is the k-th accepted stream bit
    bit          gaps;      // toggle in_valid every other cycle
    logic [7:0]  exp_therm;
    int          exp_ones;
    bit          exp_sat;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drops_after_handshake", out_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Feed n accepted bits; out_valid must stay low until the last one lands.
  task automatic feed(input logic [15:0] bits, input bit gaps, input int n);
    int k = 0;
    int guard = 0;
    bit early = 1'b0;
    while (k < n && guard < 200) begin
      in_valid = gaps ? (guard % 2 == 0) : 1'b1;
      in_bit   = bits[k];
      if (out_valid) early = 1'b1;
      if (in_valid && in_ready) k++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    chk("feed_accepts", k, n);
    chk("no_early_valid", early, 0);
  endtask

  function automatic int therm_of(input int ones);
    if (ones >= 8) return 255;
    return (1 << ones) - 1;
  endfunction

  // Reference model: a window is just a count of accepts and of ones.
  bit m_acc, m_hold;
  int m_n, m_ones;

  task automatic model_step();
    if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        if (start) begin m_acc = 1'b1; m_n = 0; m_ones = 0; end
      end
    end else if (m_acc) begin
      if (start) begin
        m_n = 0; m_ones = 0;
      end else if (in_valid) begin
        m_n++;
        m_ones += int'(in_bit);
        if (m_n == CYCLE) begin m_acc = 1'b0; m_hold = 1'b1; end
      end
    end else if (start) begin
      m_acc = 1'b1; m_n = 0; m_ones = 0;
    end
  endtask

  initial begin
    int n;

    vecs[0] = '{16'hFFFF, 1'b0, 8'hFF, 16, 1'b1, "all_ones"};
    vecs[1] = '{16'h5555, 1'b0, 8'hFF,  8, 1'b0, "alternating"};
    vecs[2] = '{16'h0007, 1'b1, 8'h07,  3, 1'b0, "three_ones_gaps"};
    vecs[3] = '{16'h0000, 1'b1, 8'h00,  0, 1'b0, "all_zeros_gaps"};
    vecs[4] = '{16'h00FF, 1'b0, 8'hFF,  8, 1'b0, "exactly_eight"};
    vecs[5] = '{16'h01FF, 1'b1, 8'hFF,  9, 1'b1, "nine_saturates"};
    vecs[6] = '{16'h8000, 1'b0, 8'h01,  1, 1'b0, "last_bit_only"};
    vecs[7] = '{16'h0003, 1'b0, 8'h03,  2, 1'b0, "two_ones"};

    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_therm",     therm,     0);
    chk("rst_ones",      ones_cnt,  0);
    chk("rst_sat",       sat,       0);

    // Minimum latency with in_valid held high: start cycle to out_valid.
    start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      start = 1'b0;
      if (out_valid) break;
    end
    in_valid = 1'b0; in_bit = 1'b0;
    chk("latency", n, 17);
    chk("lat_therm", therm, 8'hFF);
    chk("lat_ones",  ones_cnt, 16);
    chk("lat_sat",   sat, 1);
    handshake();

    // Table of complete windows
    foreach (vecs[i]) begin
      do_start();
      chk({vecs[i].name, "_ready"}, in_ready, 1);
      feed(vecs[i].bits, vecs[i].gaps, CYCLE);
      chk({vecs[i].name, "_valid"}, out_valid, 1);
      chk({vecs[i].name, "_nready"}, in_ready, 0);
      chk({vecs[i].name, "_therm"}, therm, vecs[i].exp_therm);
      chk({vecs[i].name, "_ones"},  ones_cnt, vecs[i].exp_ones);
      chk({vecs[i].name, "_sat"},   sat, vecs[i].exp_sat);
      handshake();
    end

    // Restart mid-window; the bit presented with start is discarded.
    do_start();
    feed(16'h0155, 1'b0, 10);
    chk("pre_restart_ones",  ones_cnt, 5);
    chk("pre_restart_therm", therm, 8'h1F);
    start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    chk("restart_ones",  ones_cnt, 0);
    chk("restart_therm", therm, 0);
    chk("restart_ready", in_ready, 1);
    feed(16'h0000, 1'b0, CYCLE);
    chk("restart_valid", out_valid, 1);
    chk("restart_res_therm", therm, 0);
    chk("restart_res_ones",  ones_cnt, 0);
    chk("restart_res_sat",   sat, 0);
    handshake();

    // HOLD stalls while start pulses; then start+out_ready chains directly.
    do_start();
    feed(16'hFFFF, 1'b0, CYCLE);
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      start = (i % 2 == 0);
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_frozen", {therm, 3'b000, ones_cnt, 7'b0, sat}, {8'hFF, 3'b000, 5'd16, 7'b0, 1'b1});
    end
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("chain_ready", in_ready, 1);
    chk("chain_valid", out_valid, 0);
    chk("chain_cleared", {therm, 3'b000, ones_cnt, 7'b0, sat}, 0);
    feed(16'h0003, 1'b0, CYCLE);
    chk("chain_therm", therm, 8'h03);
    chk("chain_ones", ones_cnt, 2);
    handshake();

    // Reset in the middle of a window.
    do_start();
    feed(16'h007F, 1'b0, 7);
    chk("pre_reset_ones", ones_cnt, 7);
    rst_n = 1'b0;
    #1;
    chk("in_reset_outs", {in_ready, out_valid, therm, 3'b000, ones_cnt, sat}, 0);
    tick(); tick();
    chk("held_reset_outs", {in_ready, out_valid, therm, 3'b000, ones_cnt, sat}, 0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_outs", {in_ready, out_valid, therm, 3'b000, ones_cnt, sat}, 0);
    do_start();
    feed(16'h0003, 1'b0, CYCLE);
    chk("fresh_therm", therm, 8'h03);
    chk("fresh_ones",  ones_cnt, 2);
    chk("fresh_sat",   sat, 0);
    handshake();

    // Random traffic against the reference model.
    do_reset();
    m_acc = 1'b0; m_hold = 1'b0; m_n = 0; m_ones = 0;
    for (int i = 0; i < 1500; i++) begin
      chk("random_cycle",
          {in_ready, out_valid, therm, 3'b000, ones_cnt, sat},
          {m_acc, m_hold, 8'(therm_of(m_ones)), 3'b000, CW'(m_ones), (m_ones > 8)});
      start     = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_bit    = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/thermo_acc_8.md
# thermo_acc_8

Upstream stage of the 8-input leading-one priority encoder in the 4-bit-fraction unary PE. Accumulates a unary bitstream over a fixed window of CYCLE accepted bits into an 8-bit thermometer word. Each accepted `1` shifts one more `1` into the word from the LSB. The finished word is held under a valid/ready handshake, so the encoder downstream converts it to a count of 0..8. Also reports the raw ones count and a saturation flag for overflow diagnosis.

## Interface
- `CYCLE`, default 16: window length in accepted input bits; legal range 2..256.
- `CW`, default `$clog2(CYCLE+1)`: width of the count fields; derived, do not override.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new window; single-cycle pulse.
- `in_valid` in 1: `in_bit` is valid this cycle.
- `in_bit` in 1: unary stream bit.
- `in_ready` out 1: block accepts stream bits; equals state==ACC.
- `out_ready` in 1: downstream consumes the result.
- `out_valid` out 1: `therm`, `ones_cnt` and `sat` are a finished result.
- `therm` out 8: thermometer word. Legal values are `8'h00`, `8'h01`, `8'h03`, … `8'hFF`.
- `ones_cnt` out CW: number of accepted `1`s in the window; unsaturated.
- `sat` out 1: a `1` arrived while `therm` was `8'hFF`.

## Operation
- State machine has three states: IDLE, ACC and HOLD. All outputs are registered.
- Accept: an input bit is accepted when `in_valid && in_ready`.
- IDLE:
  - `start` clears `therm`, `ones_cnt`, `sat` and the window counter `wcnt`, then moves to ACC.
  - Stream bits are ignored.
- ACC, on each accept:
  - `wcnt` increments.
  - If `in_bit`=1, `ones_cnt` increments. If `therm`≠`8'hFF`, `therm` becomes `{therm[6:0],1'b1}`; otherwise `therm` is unchanged and `sat` is set.
- Window end: the accept with `wcnt`==CYCLE-1 is included in the result. The next state is HOLD and `out_valid` rises.
- `start` during ACC:
  - Restarts the window: clears all result registers and `wcnt`, stays in ACC.
  - Any bit presented in the same cycle is discarded, even if `in_valid` is high.
- HOLD:
  - Outputs are frozen and `out_valid`=1 until `out_ready`=1.
  - On handshake: `out_valid` falls next cycle and the state goes to IDLE.
  - If `start`=1 in the handshake cycle, the state goes directly to ACC with cleared registers.
  - `start` without `out_ready` in HOLD is ignored; a result is never dropped.
- Width rules:
  - `ones_cnt` ≤ CYCLE always, so no wrap.
  - `wcnt` counts 0..CYCLE-1 and never wraps within a window.
- `therm` is always a valid thermometer code (contiguous ones from bit 0). Downstream relies on this.

## Timing
- Reset values: state IDLE, `in_ready`=0, `out_valid`=0, `therm`=0, `ones_cnt`=0, `sat`=0, `wcnt`=0.
- Reset mid-window or mid-HOLD aborts immediately. No partial result is emitted.
- `start` at edge t gives `in_ready`=1 from t+1. The first accept can occur in cycle t+1.
- Final accept at edge t gives `out_valid`=1 and `in_ready`=0 from t+1.
- With `in_valid` held high, minimum latency is CYCLE+1 cycles from `start` to `out_valid`.
- Throughput is back-to-back with no idle cycle between windows:
  - Window length is CYCLE+1 cycles (CYCLE accepts plus the HOLD handshake cycle, with `start` issued in the handshake cycle).
  - This holds only if `out_ready` is high on the first HOLD cycle.
- `in_valid` gaps stall the window with no state change. There is no timeout.

## Test plan
- Reset then `start`, CYCLE=16, 16 accepts all `1`:
  - `therm`=`8'hFF`, `ones_cnt`=16, `sat`=1.
  - `out_valid` high exactly 17 cycles after `start`.
- Stream `1,0` alternating for 16 accepts, `out_ready`=1:
  - `therm`=`8'hFF`, `ones_cnt`=8, `sat`=0.
- Stream of three `1`s then zeros, with `in_valid` toggling every other cycle:
  - `therm`=`8'h07`, `ones_cnt`=3.
  - `out_valid` only after the 16th accept, not the 16th cycle.
- `start` pulsed after 10 accepts (5 ones), then 16 accepts of all zeros:
  - Result `therm`=`8'h00`, `ones_cnt`=0, `sat`=0.
- HOLD with `out_ready`=0 for 5 cycles while `start` pulses:
  - Outputs stay frozen and `out_valid` stays 1.
  - `out_ready`+`start` together starts a new window with no idle cycle.
- Assert `rst_n`=0 mid-ACC (after 7 ones):
  - All outputs read 0 while reset is held and after release.
  - A new `start` yields a fresh result unaffected by the earlier bits.
